// File: rtl/spi_sched_if.sv
// spi_sched_if: requester-side and downstream write-bus signals of spi_sched.
// Ports (signals):
//   rq_valid/rq_last [NUM_REQ]   per-requester word pending / word ends burst
//   rq_cfg/rq_div/rq_data        packed per-requester cfg, divider and data words
//   rq_ready [NUM_REQ]           one-cycle accept pulse back to the requester
//   m_req/m_address/m_data       downstream write request, address, data
//   m_ack                        downstream one-cycle acknowledge
// Modports: master = scheduler side, slave = requesters plus downstream target.
interface spi_sched_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] rq_valid, rq_last, rq_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] rq_cfg, rq_div, rq_data;
  logic m_req, m_ack;
  logic [DATA_WIDTH-1:0] m_address, m_data;
  modport master (
    input  rq_valid, rq_last, rq_cfg, rq_div, rq_data, m_ack,
    output rq_ready, m_req, m_address, m_data
  );
  modport slave (
    output rq_valid, rq_last, rq_cfg, rq_div, rq_data, m_ack,
    input  rq_ready, m_req, m_address, m_data
  );
endinterface

// File: rtl/spi_sched.sv
// spi_sched: round-robin scheduler that programs cfg/divider and forwards data bursts downstream.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    spi_sched_if.master: requester valid/cfg/div/data/last/ready, downstream req/address/data/ack
//   busy   high while a grant is held
//   owner  index of the current or last granted requester
module spi_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ = 4,
  parameter int MAX_BURST = 6,
  parameter int DATA_ADDR = 2
) (
  input  logic clk,
  input  logic rst_n,
  spi_sched_if.master bus,
  output logic busy,
  output logic [$clog2(NUM_REQ)-1:0] owner
);
  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic [2:0] {IDLE, CFG, DIV, DATA, GAP} state_t;
  state_t state_q, state_d, nxt_q, nxt_d;
  logic [OW-1:0] owner_q, owner_d, last_q, last_d, win, idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, shcfg_q, shcfg_d, shdiv_q, shdiv_d;
  logic busy_q, busy_d, lastw_q, lastw_d, shv_q, shv_d, found, hit;
  logic [DATA_WIDTH-1:0] cfg_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] div_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] dat_a [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign cfg_a[g] = bus.rq_cfg[g*DATA_WIDTH +: DATA_WIDTH];
    assign div_a[g] = bus.rq_div[g*DATA_WIDTH +: DATA_WIDTH];
    assign dat_a[g] = bus.rq_data[g*DATA_WIDTH +: DATA_WIDTH];
  end
  // Search starts just after the last owner, so the previous owner has lowest priority.
  always_comb begin
    found = 1'b0;
    win = last_q;
    idx = last_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = OW'((int'(last_q) + i) % NUM_REQ);
      if (!found && bus.rq_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  // Downstream already holds the winner's settings: go straight to data.
  assign hit = shv_q && cfg_a[win] == shcfg_q && div_a[win] == shdiv_q;
  always_comb begin
    state_d = state_q;
    nxt_d = nxt_q;
    owner_d = owner_q;
    last_d = last_q;
    busy_d = busy_q;
    cnt_d = cnt_q;
    data_d = data_q;
    lastw_d = lastw_q;
    shcfg_d = shcfg_q;
    shdiv_d = shdiv_q;
    shv_d = shv_q;
    case (state_q)
      IDLE: if (found) begin
        owner_d = win;
        busy_d = 1'b1;
        cnt_d = '0;
        state_d = hit ? DATA : CFG;
        data_d = hit ? dat_a[win] : cfg_a[win];
        lastw_d = bus.rq_last[win];
      end
      CFG: if (bus.m_ack) begin
        shcfg_d = data_q;
        state_d = GAP;
        nxt_d = DIV;
      end
      DIV: if (bus.m_ack) begin
        shdiv_d = data_q;
        shv_d = 1'b1;
        state_d = GAP;
        nxt_d = DATA;
      end
      DATA: if (bus.m_ack) begin
        cnt_d = cnt_q + CW'(1);
        state_d = GAP;
        nxt_d = (lastw_q || cnt_q == CW'(MAX_BURST - 1)) ? IDLE : DATA;
        busy_d = !(lastw_q || cnt_q == CW'(MAX_BURST - 1));
        last_d = (lastw_q || cnt_q == CW'(MAX_BURST - 1)) ? owner_q : last_q;
      end
      GAP: begin
        // Word and its last flag are captured as the request is raised and held until ack.
        if (nxt_q == DIV) begin
          state_d = DIV;
          data_d = div_a[owner_q];
        end else if (nxt_q == DATA && bus.rq_valid[owner_q]) begin
          state_d = DATA;
          data_d = dat_a[owner_q];
          lastw_d = bus.rq_last[owner_q];
        end else begin
          state_d = IDLE;
          busy_d = 1'b0;
          last_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      nxt_q <= IDLE;
      owner_q <= '0;
      last_q <= OW'(NUM_REQ - 1);
      busy_q <= 1'b0;
      cnt_q <= '0;
      data_q <= '0;
      lastw_q <= 1'b0;
      shcfg_q <= '0;
      shdiv_q <= '0;
      shv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      nxt_q <= nxt_d;
      owner_q <= owner_d;
      last_q <= last_d;
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      lastw_q <= lastw_d;
      shcfg_q <= shcfg_d;
      shdiv_q <= shdiv_d;
      shv_q <= shv_d;
    end
  assign bus.m_req = state_q == CFG || state_q == DIV || state_q == DATA;
  assign bus.m_address = state_q == DIV ? DATA_WIDTH'(1) : state_q == DATA ? DATA_WIDTH'(DATA_ADDR) : '0;
  assign bus.m_data = data_q;
  assign bus.rq_ready = (state_q == DATA && bus.m_ack) ? NUM_REQ'(1) << owner_q : '0;
  assign busy = busy_q;
  assign owner = owner_q;
endmodule

// File: doc/spi_sched.md
SPI_SCHED -- requirements
Module: spi_sched

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 8, width of cfg, divider, data and address words.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 6, maximum data words per grant.
- DATA_ADDR, 2, downstream address used for data words (SHALL be >1).
REQ-002 Ports, one per line: name, direction, width, meaning (clock and reset first).
- clk, in, 1, single system clock; all logic on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- rq_valid, in, NUM_REQ, requester i has a data word pending.
- rq_cfg, in, NUM_REQ*DATA_WIDTH, requester i configuration word.
- rq_div, in, NUM_REQ*DATA_WIDTH, requester i clock-divider word.
- rq_data, in, NUM_REQ*DATA_WIDTH, requester i data word.
- rq_last, in, NUM_REQ, current word of requester i ends its burst.
- rq_ready, out, NUM_REQ, one-cycle pulse: word of requester i accepted downstream.
- m_req, out, 1, downstream write request.
- m_address, out, DATA_WIDTH, downstream address: 0 = cfg, 1 = divider, DATA_ADDR = data.
- m_data, out, DATA_WIDTH, downstream write data.
- m_ack, in, 1, downstream one-cycle acknowledge.
- busy, out, 1, high while a grant is held.
- owner, out, clog2(NUM_REQ), index of the current or last granted requester.

Function
REQ-003 States SHALL be IDLE, CFG, DIV, DATA and GAP.
REQ-004 IDLE: if any rq_valid is high, grant round-robin starting at (last_owner+1) mod NUM_REQ, then load owner and set busy next cycle.
REQ-005 On grant, the next state SHALL be CFG. It SHALL be DATA instead if shadow_valid is set and rq_cfg/rq_div of the winner equal shadow_cfg/shadow_div.
REQ-006 CFG: m_req=1, m_address=0, m_data=rq_cfg[owner]. On m_ack, store shadow_cfg, then go to GAP with next=DIV.
REQ-007 DIV: m_req=1, m_address=1, m_data=rq_div[owner]. On m_ack, store shadow_div, set shadow_valid, then go to GAP with next=DATA.
REQ-008 DATA entry: if rq_valid[owner]=0, release the grant and go to IDLE with no request issued. Otherwise: m_req=1, m_address=DATA_ADDR, m_data=rq_data[owner].
REQ-009 Data word acceptance on m_ack in DATA:
- rq_ready[owner] SHALL pulse for exactly that cycle.
- The burst counter SHALL increment.
- The next state SHALL be GAP.
REQ-010 The grant SHALL end after an acked word that had rq_last=1, or after the MAX_BURST-th acked word, whichever comes first. Ending a grant SHALL clear busy, update last_owner and return through GAP to IDLE.
REQ-011 Once m_req is raised, m_req, m_address and m_data SHALL stay stable until m_ack is sampled; rq_valid, rq_data and rq_cfg changes are ignored meanwhile.
REQ-012 GAP SHALL last exactly one cycle with m_req=0. Downstream ack is a pulse and SHALL never see back-to-back req.
REQ-013 m_ack while m_req=0 SHALL be ignored.
REQ-014 With downstream ack one cycle after req, each transaction SHALL take 3 cycles (req, ack, gap). A full-config single-word grant SHALL take 9 cycles from the grant edge.
REQ-015 Burst counter width SHALL be clog2(MAX_BURST+1). It SHALL clear on every grant and never wrap.
REQ-016 A requester that hits MAX_BURST with rq_valid still high SHALL rejoin arbitration with lowest priority.
REQ-017 rq_ready SHALL be one-hot or zero at all times.

Reset
REQ-018 With rst_n low, asynchronously, the following SHALL hold:
- state = IDLE.
- m_req, m_address, m_data, rq_ready and busy = 0.
- owner = 0.
- last_owner = NUM_REQ-1, so requester 0 wins first.
- shadow_valid = 0.
REQ-019 Reset mid-transaction SHALL drop m_req immediately. After release, the first grant SHALL reprogram cfg and divider.

Verification
REQ-020 Single word, ack one cycle after req: rq_valid=0001, cfg=0x41, div=0x03, data=0xA5, last=1.
- Expect writes (0,0x41), (1,0x03), (2,0xA5).
- Expect one rq_ready[0] pulse and m_req low for one cycle between writes.
- Expect busy low after the gap.
REQ-021 Same requester sends again with identical cfg/div: only the (2,data) write occurs; CFG and DIV are skipped.
REQ-022 Round robin: rq_valid=1111, all bursts of one word with last=1, identical cfg/div.
- Expect grant order 0,1,2,3,0.
- Expect owner to match each rq_ready pulse.
REQ-023 Burst cap: requester 2 streams 9 words with last=0 while requester 3 is valid.
- Expect 6 words from requester 2, then requester 3 served, then the remaining 3 words from requester 2.
REQ-024 Ack delayed 5 cycles: m_req, m_address and m_data stay stable for all 5 cycles while rq_data changes. A spurious m_ack during GAP causes no rq_ready.
REQ-025 rst_n pulsed low while m_req=1 in DIV: m_req=0 at once. The next grant issues the CFG write first.
